i2s_frame_seq: RTL and testbench
================================

// Module: i2s_frame_seq
// PURPOSE
// Frame sequencer for the I2S transceiver. Divides pclk into the serial bit clock (sck) and the
// word-select (ws). Tracks bit/channel position and schedules Tx FIFO reads and Rx FIFO writes
// at word boundaries. Sits between the register/FIFO layer and the serial shifters; it owns no
// data, only timing, strobes and error flags.
// PARAMETERS
// DIV_W    8   width of clk_div; sck half-period = clk_div+1 pclk cycles
// CNT_W    5   width of bit_idx (covers word length up to 32)
// PORTS
// pclk        in   1      system clock
// preset      in   1      reset, asynchronous, active-low
// en          in   1      run request; level-sensitive
// tx_en       in   1      enable Tx FIFO scheduling
// rx_en       in   1      enable Rx FIFO scheduling
// clk_div     in   DIV_W  sck half-period minus one
// word_len    in   2      00=8, 01=16, 10=24, 11=32 bits per channel
// tx_empty    in   1      Tx FIFO empty
// rx_full     in   1      Rx FIFO full
// clr_flags   in   1      one-cycle clear of sticky flags
// sck         out  1      serial bit clock; idles low
// ws          out  1      word select; 0=left, 1=right; idles low
// sck_rise_p  out  1      1-cycle strobe, cycle before sck rises (receiver sample point)
// sck_fall_p  out  1      1-cycle strobe, cycle before sck falls (transmitter shift point)
// bit_idx     out  CNT_W  bit index within current word, MSB first = 0
// tx_ren      out  1      Tx FIFO read pulse / shifter load
// rx_wen      out  1      Rx FIFO write pulse (word complete)
// underrun    out  1      sticky: Tx word needed while tx_empty
// overrun     out  1      sticky: Rx word completed while rx_full
// busy        out  1      high in any state except IDLE
// BEHAVIOUR
// - Reset: all outputs 0; FSM=IDLE; div_cnt=0; latched WL/div cleared.
// - FSM: IDLE -> START on en=1. START lasts one cycle, latches clk_div/word_len (WL), then -> RUN.
//   RUN -> STOP when en=0. STOP -> IDLE at the end of the right-channel word.
//   STOP -> RUN if en returns to 1 before that boundary.
// - Divider (RUN/STOP only): div_cnt 0..div_l. At div_cnt==div_l: div_cnt<=0, sck<=~sck.
//   rise_evt = terminal & sck==0; fall_evt = terminal & sck==1. Strobes are combinational
//   copies of these events. clk_div=0 gives sck period 2 pclk.
// - Bit tracking on fall_evt: bit_idx increments. At bit_idx==WL-1 (word boundary): bit_idx<=0,
//   ws<=~ws. A boundary with ws==1 is a frame boundary; there clk_div/word_len are re-latched.
// - Tx: tx_ren pulses in the START cycle (left word), then in each word-boundary fall_evt cycle,
//   only if tx_en & !tx_empty & the next word will be sent (not final STOP boundary).
//   If tx_en & tx_empty at that point: no tx_ren, underrun<=1 (shifter sends zeros).
// - Rx: on rise_evt with bit_idx==WL-1 and rx_en: rx_wen pulses 1 cycle later (word in shifter).
//   If rx_full in that cycle: no rx_wen, overrun<=1.
// - Flags: set has priority over clr_flags in the same cycle.
// - STOP end: sck held low, ws<=0, bit_idx<=0, div_cnt<=0, busy<=0 next cycle.
// - Config changes mid-frame are ignored until the next frame boundary.
// - en toggling 1->0->1 within one frame gives no glitch on sck/ws.
// - preset low mid-frame: immediate return to reset values, no pending strobes.
// TESTING
// - clk_div=1, WL=16, tx/rx_en=1, FIFOs ready, en=1 -> sck period 4 pclk; ws toggles every 16
//   sck; tx_ren in START cycle and at every word boundary.
// - clk_div=0, WL=8 -> sck period 2; ws period 16 sck; exactly one rx_wen per word,
//   1 cycle after last rise.
// - tx_empty=1 at 2nd word boundary -> no tx_ren; underrun=1 held; clr_flags -> 0; clr_flags
//   coincident with new underrun -> stays 1.
// - rx_full=1 at word end -> no rx_wen, overrun=1.
// - en dropped mid-left word (WL=24) -> right word completes, then sck=0, ws=0, busy=0.
//   No tx_ren at the final boundary.
// - word_len 16->32 mid-frame -> current frame stays 16; next frame 32.
//   preset pulse mid-word -> all outputs 0 same cycle.

Source files
------------

// File: rtl/i2s_frame_seq_if.sv
// Bus between the I2S register/FIFO layer and the frame sequencer.
// The master drives run/config/FIFO status; the slave (sequencer) returns timing, strobes and flags.
interface i2s_frame_seq_if #(
   parameter int DIV_W = 8,
   parameter int CNT_W = 5
);
   logic             en;
   logic             tx_en;
   logic             rx_en;
   logic [DIV_W-1:0] clk_div;
   logic [1:0]       word_len;
   logic             tx_empty;
   logic             rx_full;
   logic             clr_flags;

   logic             sck;
   logic             ws;
   logic             sck_rise_p;
   logic             sck_fall_p;
   logic [CNT_W-1:0] bit_idx;
   logic             tx_ren;
   logic             rx_wen;
   logic             underrun;
   logic             overrun;
   logic             busy;

   modport master (
      output en, tx_en, rx_en, clk_div, word_len, tx_empty, rx_full, clr_flags,
      input  sck, ws, sck_rise_p, sck_fall_p, bit_idx, tx_ren, rx_wen, underrun, overrun, busy
   );

   modport slave (
      input  en, tx_en, rx_en, clk_div, word_len, tx_empty, rx_full, clr_flags,
      output sck, ws, sck_rise_p, sck_fall_p, bit_idx, tx_ren, rx_wen, underrun, overrun, busy
   );
endinterface

// File: rtl/i2s_frame_seq.sv
// I2S frame sequencer: divides pclk into sck/ws, tracks bit position and schedules
// Tx FIFO reads / Rx FIFO writes at word boundaries. Owns timing only, no data.
module i2s_frame_seq #(
   parameter int DIV_W = 8,
   parameter int CNT_W = 5
) (
   input  logic            pclk,
   input  logic            preset,
   i2s_frame_seq_if.slave  bus
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [DIV_W-1:0] div_l_q, div_l_d;
   logic [1:0]       wl_q, wl_d;
   logic [CNT_W-1:0] bit_idx_q, bit_idx_d;
   logic             sck_q, sck_d;
   logic             ws_q, ws_d;
   logic             rx_pend_q, rx_pend_d;
   logic             underrun_q, underrun_d;
   logic             overrun_q, overrun_d;

   logic             active;
   logic             terminal;
   logic             rise_evt;
   logic             fall_evt;
   logic [CNT_W-1:0] wl_last;
   logic             bit_last;
   logic             word_end;
   logic             final_end;
   logic             tx_need;
   logic             tx_load;
   logic             tx_starve;
   logic             rx_capture;
   logic             rx_write;
   logic             rx_lost;

   // Word lengths are multiples of 8, so the last bit index is {wl,3'b111}.
   assign wl_last    = CNT_W'({wl_q, 3'b111});
   assign active     = (state_q == ST_RUN) || (state_q == ST_STOP);
   assign terminal   = active && (div_cnt_q == div_l_q);
   assign rise_evt   = terminal && !sck_q;
   assign fall_evt   = terminal && sck_q;
   assign bit_last   = (bit_idx_q == wl_last);
   assign word_end   = fall_evt && bit_last;
   assign final_end  = (state_q == ST_STOP) && !bus.en && word_end && ws_q;

   // A Tx word is needed for the first left word and for every word that follows a boundary,
   // except the boundary that ends the run.
   assign tx_need    = (state_q == ST_START) || (word_end && !final_end);
   assign tx_load    = tx_need && bus.tx_en && !bus.tx_empty;
   assign tx_starve  = tx_need && bus.tx_en && bus.tx_empty;

   // The last bit is sampled on the rise; the word is complete in the shifter one cycle later.
   assign rx_capture = rise_evt && bit_last && bus.rx_en;
   assign rx_write   = rx_pend_q && !bus.rx_full;
   assign rx_lost    = rx_pend_q && bus.rx_full;

   always_comb begin
      state_d    = state_q;
      div_cnt_d  = div_cnt_q;
      div_l_d    = div_l_q;
      wl_d       = wl_q;
      bit_idx_d  = bit_idx_q;
      sck_d      = sck_q;
      ws_d       = ws_q;
      rx_pend_d  = rx_capture;
      underrun_d = tx_starve || (underrun_q && !bus.clr_flags);
      overrun_d  = rx_lost || (overrun_q && !bus.clr_flags);

      case (state_q)
         ST_IDLE: begin
            if (bus.en) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            div_l_d   = bus.clk_div;
            wl_d      = bus.word_len;
            div_cnt_d = '0;
            bit_idx_d = '0;
            sck_d     = 1'b0;
            ws_d      = 1'b0;
            state_d   = ST_RUN;
         end
         ST_RUN: begin
            if (!bus.en) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bus.en) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (active) begin
         if (terminal) begin
            div_cnt_d = '0;
            sck_d     = !sck_q;
         end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
         end

         if (fall_evt) begin
            if (bit_last) begin
               bit_idx_d = '0;
               ws_d      = !ws_q;
               // Configuration only takes effect at a frame boundary so frames stay uniform.
               if (ws_q) begin
                  div_l_d = bus.clk_div;
                  wl_d    = bus.word_len;
               end
            end else begin
               bit_idx_d = bit_idx_q + CNT_W'(1);
            end
         end

         if (final_end) begin
            state_d   = ST_IDLE;
            sck_d     = 1'b0;
            ws_d      = 1'b0;
            bit_idx_d = '0;
            div_cnt_d = '0;
         end
      end
   end

   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         state_q    <= ST_IDLE;
         div_cnt_q  <= '0;
         div_l_q    <= '0;
         wl_q       <= '0;
         bit_idx_q  <= '0;
         sck_q      <= 1'b0;
         ws_q       <= 1'b0;
         rx_pend_q  <= 1'b0;
         underrun_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_cnt_q  <= div_cnt_d;
         div_l_q    <= div_l_d;
         wl_q       <= wl_d;
         bit_idx_q  <= bit_idx_d;
         sck_q      <= sck_d;
         ws_q       <= ws_d;
         rx_pend_q  <= rx_pend_d;
         underrun_q <= underrun_d;
         overrun_q  <= overrun_d;
      end
   end

   assign bus.sck        = sck_q;
   assign bus.ws         = ws_q;
   assign bus.sck_rise_p = rise_evt;
   assign bus.sck_fall_p = fall_evt;
   assign bus.bit_idx    = bit_idx_q;
   assign bus.tx_ren     = tx_load;
   assign bus.rx_wen     = rx_write;
   assign bus.underrun   = underrun_q;
   assign bus.overrun    = overrun_q;
   assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_i2s_frame_seq.sv
// Directed bench for the I2S frame sequencer: event cycles are logged relative to the START
// cycle (rel 0) and compared against hand-computed positions.
module tb_i2s_frame_seq;
   localparam int NREC  = 32;
   localparam int NSNAP = 256;

   logic pclk   = 1'b0;
   logic preset = 1'b0;

   always #5 pclk = ~pclk;

   i2s_frame_seq_if bus_if ();

   i2s_frame_seq dut (
      .pclk   (pclk),
      .preset (preset),
      .bus    (bus_if.slave)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   int   tx_cyc[NREC], rx_cyc[NREC], ws_cyc[NREC], sckr_cyc[NREC], risep_cyc[NREC], fallp_cyc[NREC];
   int   tx_n, rx_n, ws_n, sckr_n, risep_n, fallp_n;
   logic sck_at[NSNAP], ws_at[NSNAP], busy_at[NSNAP], und_at[NSNAP], ovr_at[NSNAP];
   logic [4:0] bidx_at[NSNAP];
   int   rel = 100000;
   logic busy_prev = 1'b0, ws_prev = 1'b0, sck_prev = 1'b0;

   // Monitor: sample on the falling edge, away from the active edge.
   always @(negedge pclk) begin
      if (bus_if.busy && !busy_prev) rel = 0;
      else rel++;
      if (rel < NSNAP) begin
         sck_at[rel]  = bus_if.sck;
         ws_at[rel]   = bus_if.ws;
         busy_at[rel] = bus_if.busy;
         und_at[rel]  = bus_if.underrun;
         ovr_at[rel]  = bus_if.overrun;
         bidx_at[rel] = bus_if.bit_idx;
      end
      if (bus_if.tx_ren && tx_n < NREC) begin tx_cyc[tx_n] = rel; tx_n++; end
      if (bus_if.rx_wen && rx_n < NREC) begin rx_cyc[rx_n] = rel; rx_n++; end
      if ((bus_if.ws != ws_prev) && ws_n < NREC) begin ws_cyc[ws_n] = rel; ws_n++; end
      if (bus_if.sck && !sck_prev && sckr_n < NREC) begin sckr_cyc[sckr_n] = rel; sckr_n++; end
      if (bus_if.sck_rise_p && risep_n < NREC) begin risep_cyc[risep_n] = rel; risep_n++; end
      if (bus_if.sck_fall_p && fallp_n < NREC) begin fallp_cyc[fallp_n] = rel; fallp_n++; end
      busy_prev = bus_if.busy;
      ws_prev   = bus_if.ws;
      sck_prev  = bus_if.sck;
   end

   task automatic clear_rec();
      for (int i = 0; i < NREC; i++) begin
         tx_cyc[i] = -1; rx_cyc[i] = -1; ws_cyc[i] = -1;
         sckr_cyc[i] = -1; risep_cyc[i] = -1; fallp_cyc[i] = -1;
      end
      tx_n = 0; rx_n = 0; ws_n = 0; sckr_n = 0; risep_n = 0; fallp_n = 0;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   task automatic do_reset();
      bus_if.en = 1'b0;
      preset = 1'b0;
      wait_cyc(2);
      preset = 1'b1;
      wait_cyc(1);
   endtask

   // Leaves the bench one step into the START cycle (rel 0).
   task automatic start_run(input logic [7:0] div, input logic [1:0] wl);
      bus_if.clk_div   = div;
      bus_if.word_len  = wl;
      bus_if.tx_en     = 1'b1;
      bus_if.rx_en     = 1'b1;
      bus_if.tx_empty  = 1'b0;
      bus_if.rx_full   = 1'b0;
      bus_if.clr_flags = 1'b0;
      clear_rec();
      bus_if.en = 1'b1;
      wait_cyc(1);
   endtask

   initial begin
      bus_if.en = 1'b0; bus_if.tx_en = 1'b0; bus_if.rx_en = 1'b0;
      bus_if.clk_div = '0; bus_if.word_len = '0;
      bus_if.tx_empty = 1'b0; bus_if.rx_full = 1'b0; bus_if.clr_flags = 1'b0;
      clear_rec();

      // Reset state
      wait_cyc(3);
      check_eq("rst_outs", int'({bus_if.sck, bus_if.ws, bus_if.busy, bus_if.tx_ren, bus_if.rx_wen,
                                 bus_if.underrun, bus_if.overrun, bus_if.sck_rise_p, bus_if.sck_fall_p}), 0);
      check_eq("rst_bit_idx", int'(bus_if.bit_idx), 0);
      preset = 1'b1;
      wait_cyc(1);

      // clk_div=1, 16-bit words: sck period 4, word boundaries every 64 pclk
      start_run(8'd1, 2'b01);
      wait_cyc(200);
      check_eq("t1_busy0", int'(busy_at[0]), 1);
      check_eq("t1_tx0", tx_cyc[0], 0);
      check_eq("t1_tx1", tx_cyc[1], 64);
      check_eq("t1_tx2", tx_cyc[2], 128);
      check_eq("t1_tx3", tx_cyc[3], 192);
      check_eq("t1_rx0", rx_cyc[0], 63);
      check_eq("t1_rx1", rx_cyc[1], 127);
      check_eq("t1_ws0", ws_cyc[0], 65);
      check_eq("t1_ws1", ws_cyc[1], 129);
      check_eq("t1_sckr0", sckr_cyc[0], 3);
      check_eq("t1_sckr1", sckr_cyc[1], 7);
      check_eq("t1_risep0", risep_cyc[0], 2);
      check_eq("t1_fallp0", fallp_cyc[0], 4);
      check_eq("t1_bidx3", int'(bidx_at[3]), 0);
      check_eq("t1_bidx5", int'(bidx_at[5]), 1);
      check_eq("t1_bidx64", int'(bidx_at[64]), 15);
      check_eq("t1_bidx65", int'(bidx_at[65]), 0);
      do_reset();

      // clk_div=0, 8-bit words: sck period 2, one rx_wen per word
      start_run(8'd0, 2'b00);
      wait_cyc(100);
      check_eq("t2_sckr0", sckr_cyc[0], 2);
      check_eq("t2_sckr1", sckr_cyc[1], 4);
      check_eq("t2_ws0", ws_cyc[0], 17);
      check_eq("t2_ws1", ws_cyc[1], 33);
      check_eq("t2_ws2", ws_cyc[2], 49);
      check_eq("t2_rx_n", rx_n, 6);
      check_eq("t2_rx0", rx_cyc[0], 16);
      check_eq("t2_rx5", rx_cyc[5], 96);
      check_eq("t2_tx_n", tx_n, 7);
      do_reset();

      // Underrun / overrun and flag clearing
      start_run(8'd0, 2'b00);
      wait_cyc(16); bus_if.rx_full = 1'b1;
      wait_cyc(1);  bus_if.rx_full = 1'b0;
      wait_cyc(15); bus_if.tx_empty = 1'b1;
      wait_cyc(1);  bus_if.tx_empty = 1'b0;
      wait_cyc(7);  bus_if.clr_flags = 1'b1;
      wait_cyc(1);  bus_if.clr_flags = 1'b0;
      wait_cyc(7);  bus_if.clr_flags = 1'b1; bus_if.tx_empty = 1'b1;
      wait_cyc(1);  bus_if.clr_flags = 1'b0; bus_if.tx_empty = 1'b0;
      wait_cyc(21);
      check_eq("t3_tx_n", tx_n, 3);
      check_eq("t3_tx1", tx_cyc[1], 16);
      check_eq("t3_tx2", tx_cyc[2], 64);
      check_eq("t3_rx_n", rx_n, 3);
      check_eq("t3_rx0", rx_cyc[0], 32);
      check_eq("t3_ovr16", int'(ovr_at[16]), 0);
      check_eq("t3_ovr17", int'(ovr_at[17]), 1);
      check_eq("t3_und32", int'(und_at[32]), 0);
      check_eq("t3_und33", int'(und_at[33]), 1);
      check_eq("t3_und40", int'(und_at[40]), 1);
      check_eq("t3_und41", int'(und_at[41]), 0);
      check_eq("t3_ovr41", int'(ovr_at[41]), 0);
      check_eq("t3_und49", int'(und_at[49]), 1);
      do_reset();

      // en dropped mid-left word, 24-bit words: right word completes then idle
      start_run(8'd0, 2'b10);
      wait_cyc(10); bus_if.en = 1'b0;
      wait_cyc(100);
      check_eq("t5_bidx47", int'(bidx_at[47]), 23);
      check_eq("t5_tx_n", tx_n, 2);
      check_eq("t5_tx1", tx_cyc[1], 48);
      check_eq("t5_rx_n", rx_n, 2);
      check_eq("t5_rx1", rx_cyc[1], 96);
      check_eq("t5_busy96", int'(busy_at[96]), 1);
      check_eq("t5_busy97", int'(busy_at[97]), 0);
      check_eq("t5_ws95", int'(ws_at[95]), 1);
      check_eq("t5_ws97", int'(ws_at[97]), 0);
      check_eq("t5_sck97", int'(sck_at[97]), 0);
      check_eq("t5_bidx97", int'(bidx_at[97]), 0);
      check_eq("t5_idle105", int'({busy_at[105], sck_at[105], ws_at[105]}), 0);
      do_reset();

      // word_len 16->32 mid-frame, then asynchronous reset mid-word
      start_run(8'd0, 2'b01);
      wait_cyc(10); bus_if.word_len = 2'b11;
      wait_cyc(140);
      check_eq("t6_tx_n", tx_n, 4);
      check_eq("t6_tx3", tx_cyc[3], 128);
      check_eq("t6_ws40", int'(ws_at[40]), 1);
      check_eq("t6_ws65", int'(ws_at[65]), 0);
      check_eq("t6_ws97", int'(ws_at[97]), 0);
      check_eq("t6_ws129", int'(ws_at[129]), 1);
      check_eq("t6_pre_ws", int'(bus_if.ws), 1);
      check_eq("t6_pre_busy", int'(bus_if.busy), 1);
      preset = 1'b0;
      #1;
      check_eq("t7_ws", int'(bus_if.ws), 0);
      check_eq("t7_busy", int'(bus_if.busy), 0);
      check_eq("t7_sck", int'(bus_if.sck), 0);
      check_eq("t7_bit_idx", int'(bus_if.bit_idx), 0);
      check_eq("t7_strobes", int'({bus_if.tx_ren, bus_if.rx_wen, bus_if.sck_rise_p, bus_if.sck_fall_p,
                                   bus_if.underrun, bus_if.overrun}), 0);
      wait_cyc(2);
      preset = 1'b1;
      wait_cyc(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
